digit_display_controller: RTL

- Sequences the two-digit OLED character overlay.
- Turns left/right/centre button presses into the `set9[1:0]` enable pair consumed by the character-drawing block, including a timed blink mode.
- Drives the circle-highlight request from the synchronised button levels, replacing ad-hoc polling in the draw path.
- Sits between the pushbutton inputs and the OLED drawing logic, clocked by the 1 kHz system tick.

---
 rtl/oled_pkg.sv | 23 ++
 rtl/digit_display_controller_if.sv | 12 +
 rtl/btn_press_sync.sv | 50 +++++
 rtl/digit_display_controller.sv | 110 +++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED character overlay: FSM state encoding,
// RGB565 colour constants and default timing parameters.
package oled_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        BOTH  = 3'd3,
        BLINK = 3'd4
    } state_e;

    localparam logic [15:0] BLACK   = 16'h0000;
    localparam logic [15:0] WHITE   = 16'hFFFF;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] BLUE    = 16'h001F;
    localparam logic [15:0] MAGENTA = 16'hF81F;

    localparam int DEBOUNCE_MS_DEF   = 200;
    localparam int BLINK_HALF_MS_DEF = 500;

endpackage

// File: rtl/digit_display_controller_if.sv
// Button inputs and overlay outputs between the pushbuttons and the draw path.
interface digit_display_controller_if;
    logic       btnL;
    logic       btnR;
    logic       btnC;
    logic [1:0] set9;
    logic       highlight;
    logic [2:0] mode;

    modport master (output btnL, btnR, btnC, input set9, highlight, mode);
    modport slave  (input btnL, btnR, btnC, output set9, highlight, mode);
endinterface

// File: rtl/btn_press_sync.sv
// One pushbutton: 2-FF synchroniser, rising-edge detect and a post-press
// lockout so bounce and long holds yield exactly one press.
module btn_press_sync
    import oled_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter int CNT_W       = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] LOCK_INIT = CNT_W'(DEBOUNCE_MS - 1);

    logic             s1_q, s2_q, p_q;
    logic [CNT_W-1:0] lock_q, lock_d;
    logic             press;

    // Press is combinational from registers so the FSM sees it one edge
    // after the synchronised level rises.
    assign press   = s2_q & ~p_q & (lock_q == '0);
    assign press_o = press;
    assign level_o = s2_q;

    always_comb begin
        lock_d = lock_q;
        if (press)
            lock_d = LOCK_INIT;
        else if (lock_q != '0)
            lock_d = lock_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            p_q    <= 1'b0;
            lock_q <= '0;
        end else begin
            s1_q   <= btn_i;
            s2_q   <= s1_q;
            p_q    <= s2_q;
            lock_q <= lock_d;
        end
    end

endmodule

// File: rtl/digit_display_controller.sv
// Two-digit overlay sequencer: button presses walk the set9 enable FSM,
// including a timed blink mode; all outputs are registered.
module digit_display_controller
    import oled_pkg::*;
#(
    parameter int DEBOUNCE_MS   = DEBOUNCE_MS_DEF,
    parameter int BLINK_HALF_MS = BLINK_HALF_MS_DEF,
    parameter int CNT_W         = 10
) (
    input  logic                        clock,
    input  logic                        resetn,
    digit_display_controller_if.slave   bus
);

    localparam logic [CNT_W-1:0] BLINK_INIT = CNT_W'(BLINK_HALF_MS - 1);

    logic press_l, press_r, press_c;
    logic lvl_l, lvl_r, unused_lvl_c;

    btn_press_sync #(.DEBOUNCE_MS(DEBOUNCE_MS), .CNT_W(CNT_W)) u_btn_l (
        .clk_i(clock), .rst_ni(resetn), .btn_i(bus.btnL),
        .level_o(lvl_l), .press_o(press_l)
    );
    btn_press_sync #(.DEBOUNCE_MS(DEBOUNCE_MS), .CNT_W(CNT_W)) u_btn_r (
        .clk_i(clock), .rst_ni(resetn), .btn_i(bus.btnR),
        .level_o(lvl_r), .press_o(press_r)
    );
    btn_press_sync #(.DEBOUNCE_MS(DEBOUNCE_MS), .CNT_W(CNT_W)) u_btn_c (
        .clk_i(clock), .rst_ni(resetn), .btn_i(bus.btnC),
        .level_o(unused_lvl_c), .press_o(press_c)
    );

    state_e           state_q, state_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] blink_q, blink_d;
    logic [1:0]       set9_q, set9_d;
    logic [2:0]       mode_q, mode_d;
    logic             highlight_q, highlight_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            blink_q     <= '0;
            set9_q      <= 2'b00;
            mode_q      <= 3'd0;
            highlight_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            blink_q     <= blink_d;
            set9_q      <= set9_d;
            mode_q      <= mode_d;
            highlight_q <= highlight_d;
        end
    end

    // Clear has absolute priority over any L/R press in the same cycle.
    always_comb begin
        state_d = state_q;
        if (press_c) begin
            state_d = IDLE;
        end else if (press_l | press_r) begin
            case (state_q)
                IDLE:    state_d = (press_l & press_r) ? BOTH  : (press_l ? LEFT : RIGHT);
                LEFT:    state_d = (press_l & press_r) ? RIGHT : (press_l ? IDLE : BOTH);
                RIGHT:   state_d = (press_l & press_r) ? LEFT  : (press_r ? IDLE : BOTH);
                BOTH:    state_d = (press_l & press_r) ? BLINK : (press_l ? RIGHT : LEFT);
                BLINK:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are computed from next state so set9/mode register together
    // with the state change; blink phase starts lit on entry.
    always_comb begin
        phase_d = 1'b0;
        blink_d = '0;
        if (state_d == BLINK) begin
            if (state_q != BLINK) begin
                phase_d = 1'b1;
                blink_d = BLINK_INIT;
            end else if (blink_q == '0) begin
                phase_d = ~phase_q;
                blink_d = BLINK_INIT;
            end else begin
                phase_d = phase_q;
                blink_d = blink_q - CNT_W'(1);
            end
        end

        case (state_d)
            IDLE:    set9_d = 2'b00;
            LEFT:    set9_d = 2'b10;
            RIGHT:   set9_d = 2'b01;
            BOTH:    set9_d = 2'b11;
            BLINK:   set9_d = {2{phase_d}};
            default: set9_d = 2'b00;
        endcase

        mode_d      = state_d;
        highlight_d = lvl_l | lvl_r;
    end

    assign bus.set9      = set9_q;
    assign bus.mode      = mode_q;
    assign bus.highlight = highlight_q;

endmodule
